// File: rtl/tone_burst_scheduler_if.sv
// Ready/valid sample stream used on both the source and sink side
// of the tone burst scheduler.
interface tone_burst_scheduler_if #(
    parameter int DATA_W = 24
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/tone_burst_scheduler.sv
// Gates a continuous sample source into ON/OFF tone bursts.
// ON samples are attenuated; OFF samples are drained and replaced by zeros.
module tone_burst_scheduler #(
    parameter int DATA_W  = 24,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [CNT_W-1:0]       on_len,
    input  logic [CNT_W-1:0]       off_len,
    input  logic [BURST_W-1:0]     burst_count,
    input  logic [2:0]             atten,
    tone_burst_scheduler_if.slave  src,
    tone_burst_scheduler_if.master snk,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]   cfg_on;
    logic [CNT_W-1:0]   cfg_off;
    logic [BURST_W-1:0] cfg_bursts;
    logic [2:0]         cfg_atten;

    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   sample_inc;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_inc;

    logic              xfer;
    logic              accept_start;
    logic              on_end;
    logic              off_end;
    logic              last_burst;
    logic              done_nx;
    logic [DATA_W-1:0] shifted;

    assign busy         = (state != IDLE);
    assign src.ready    = busy && (!snk.valid || snk.ready);
    assign xfer         = src.valid && src.ready;
    assign accept_start = (state == IDLE) && start && !stop
                          && (on_len != '0);

    assign sample_inc = sample_cnt + CNT_W'(1);
    assign burst_inc  = burst_cnt + BURST_W'(1);
    assign on_end     = xfer && (state == ON) && (sample_inc == cfg_on);
    assign off_end    = xfer && (state == OFF) && (sample_inc == cfg_off);
    assign last_burst = (cfg_bursts != '0) && (burst_inc == cfg_bursts);
    assign shifted    = $signed(src.data) >>> cfg_atten;

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        if (stop) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_start)
                        state_nx = ON;
                end
                ON: begin
                    if (on_end) begin
                        if (last_burst) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end else if (cfg_off != '0) begin
                            state_nx = OFF;
                        end
                    end
                end
                OFF: begin
                    if (off_end)
                        state_nx = ON;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_on     <= '0;
            cfg_off    <= '0;
            cfg_bursts <= '0;
            cfg_atten  <= '0;
        end else if (accept_start) begin
            cfg_on     <= on_len;
            cfg_off    <= off_len;
            cfg_bursts <= burst_count;
            cfg_atten  <= atten;
        end
    end

    // Sample count restarts at every phase boundary, including ON->ON.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (stop || state == IDLE || on_end || off_end) begin
            sample_cnt <= '0;
        end else if (xfer) begin
            sample_cnt <= sample_inc;
        end
    end

    // Infinite mode saturates so the count never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (accept_start) begin
            burst_cnt <= '0;
        end else if (on_end && !stop) begin
            if (cfg_bursts != '0 || burst_cnt != '1)
                burst_cnt <= burst_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snk.valid <= 1'b0;
            snk.data  <= '0;
        end else if (xfer) begin
            snk.valid <= 1'b1;
            snk.data  <= (state == ON) ? shifted : '0;
        end else if (snk.ready) begin
            snk.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_burst_scheduler.sv
// Directed bench for tone_burst_scheduler: bursts, attenuation,
// back-pressure, infinite mode with stop, async reset, start filtering.
module tb_tone_burst_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] on_len = '0;
    logic [15:0] off_len = '0;
    logic [7:0]  burst_count = '0;
    logic [2:0]  atten = '0;
    logic        busy;
    logic        done;

    tone_burst_scheduler_if #(.DATA_W(24)) src_if ();
    tone_burst_scheduler_if #(.DATA_W(24)) snk_if ();

    tone_burst_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .on_len      (on_len),
        .off_len     (off_len),
        .burst_count (burst_count),
        .atten       (atten),
        .src         (src_if),
        .snk         (snk_if),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [23:0] ramp;
    logic        src_en;
    logic [23:0] got[$];
    int          ndone;

    logic        o_busy, o_done, o_sv, o_sr;
    logic [23:0] o_sd;

    // One clock: present source, observe away from the edge, record transfers.
    task automatic cycle();
        logic sxf, kxf;
        src_if.data  = ramp;
        src_if.valid = src_en;
        #1;
        o_busy = busy;
        o_done = done;
        o_sv   = snk_if.valid;
        o_sr   = src_if.ready;
        o_sd   = snk_if.data;
        if (done) ndone++;
        sxf = src_if.valid && src_if.ready;
        kxf = snk_if.valid && snk_if.ready;
        @(posedge clk);
        if (sxf) ramp = ramp + 24'd1;
        if (kxf) got.push_back(o_sd);
        @(negedge clk);
    endtask

    task automatic clear_obs();
        got.delete();
        ndone = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [15:0] on_v, input logic [15:0] off_v,
                               input logic [7:0] bc, input logic [2:0] at);
        on_len      = on_v;
        off_len     = off_v;
        burst_count = bc;
        atten       = at;
        start       = 1'b1;
        cycle();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        src_en       = 1'b1;
        ramp         = 24'd1;
        snk_if.ready = 1'b1;
        src_if.valid = 1'b1;
        src_if.data  = 24'd1;
        #3;
        if ({busy, done, snk_if.valid, src_if.ready} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000",
                     {busy, done, snk_if.valid, src_if.ready});
        end
        total++;
        if (snk_if.data !== 24'd0) begin
            bad++;
            $display("FAIL reset_data got=%h want=000000", snk_if.data);
        end
        total++;
        @(negedge clk);
        reset = 1'b0;
        cycle();
        if (o_busy !== 1'b0 || o_sr !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b src_ready=%b want 0 0", o_busy, o_sr);
        end
        total++;
    endtask

    task automatic test_bursts();
        logic [23:0] exp[10];
        exp = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd0,
                24'd0, 24'd7, 24'd8, 24'd9, 24'd10};
        do_reset();
        clear_obs();
        ramp = 24'd1;
        snk_if.ready = 1'b1;
        pulse_start(16'd4, 16'd2, 8'd2, 3'd0);
        for (int i = 0; i < 20; i++) cycle();
        if (got.size() !== 10) begin
            bad++;
            $display("FAIL burst_count_samples got=%0d want=10", got.size());
        end
        total++;
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) begin
                if (got[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL burst_sample[%0d] got=%0d want=%0d", i, got[i], exp[i]);
                end
                total++;
            end
        end
        if (ndone !== 1) begin
            bad++;
            $display("FAIL burst_done got=%0d pulses want=1", ndone);
        end
        total++;
        if (o_busy !== 1'b0 || o_sr !== 1'b0) begin
            bad++;
            $display("FAIL burst_idle busy=%b src_ready=%b want 0 0", o_busy, o_sr);
        end
        total++;
        if (ramp !== 24'd11) begin
            bad++;
            $display("FAIL burst_src_drained got=%0d want=11", ramp);
        end
        total++;
    endtask

    task automatic test_atten();
        logic [2:0]  at_t[4];
        logic [23:0] in_t[4];
        logic [23:0] ex_t[4];
        at_t = '{3'd3, 3'd3, 3'd0, 3'd7};
        in_t = '{24'h800000, 24'h7FFFFF, 24'h123456, 24'hFFFF00};
        ex_t = '{24'hF00000, 24'h0FFFFF, 24'h123456, 24'hFFFFFE};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            clear_obs();
            ramp = in_t[k];
            snk_if.ready = 1'b1;
            pulse_start(16'd1, 16'd0, 8'd1, at_t[k]);
            for (int i = 0; i < 5; i++) cycle();
            if (got.size() !== 1 || got[0] !== ex_t[k]) begin
                bad++;
                $display("FAIL atten[%0d] n=%0d got=%h want=%h",
                         k, got.size(), (got.size() > 0) ? got[0] : 24'hx, ex_t[k]);
            end
            total++;
        end
    endtask

    task automatic test_back_pressure();
        logic        prev_stall;
        logic [23:0] prev_sd;
        int          stall_bad;
        int          stalls;
        do_reset();
        clear_obs();
        ramp = 24'd100;
        snk_if.ready = 1'b1;
        pulse_start(16'd6, 16'd0, 8'd1, 3'd0);
        prev_stall = 1'b0;
        prev_sd    = '0;
        stall_bad  = 0;
        stalls     = 0;
        for (int i = 0; i < 40; i++) begin
            snk_if.ready = i[0];
            cycle();
            if (prev_stall && (o_sv !== 1'b1 || o_sd !== prev_sd)) begin
                stall_bad++;
                $display("FAIL stall_hold cyc=%0d valid=%b data=%h want 1 %h",
                         i, o_sv, o_sd, prev_sd);
            end
            if (o_sv && !snk_if.ready) begin
                stalls++;
                if (o_sr !== 1'b0) begin
                    stall_bad++;
                    $display("FAIL stall_src_ready cyc=%0d got=%b want=0", i, o_sr);
                end
            end
            prev_stall = o_sv && !snk_if.ready;
            prev_sd    = o_sd;
        end
        bad += (stall_bad != 0) ? 1 : 0;
        total++;
        if (stalls < 3) begin
            bad++;
            $display("FAIL stall_seen got=%0d want>=3", stalls);
        end
        total++;
        if (got.size() !== 6) begin
            bad++;
            $display("FAIL bp_samples got=%0d want=6", got.size());
        end
        total++;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== 24'd100 + 24'(i)) begin
                bad++;
                $display("FAIL bp_sample[%0d] got=%0d want=%0d", i, got[i], 100 + i);
            end
            total++;
        end
        if (ndone !== 1) begin
            bad++;
            $display("FAIL bp_done got=%0d want=1", ndone);
        end
        total++;
    endtask

    task automatic test_infinite_stop();
        logic [23:0] last;
        do_reset();
        clear_obs();
        ramp = 24'd1;
        snk_if.ready = 1'b1;
        pulse_start(16'd3, 16'd0, 8'd0, 3'd0);
        for (int i = 0; i < 20; i++) cycle();
        if (ndone !== 0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL inf_running done=%0d busy=%b want 0 1", ndone, o_busy);
        end
        total++;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        last = ramp - 24'd1;
        cycle();
        if (o_busy !== 1'b0 || o_sr !== 1'b0) begin
            bad++;
            $display("FAIL stop_idle busy=%b src_ready=%b want 0 0", o_busy, o_sr);
        end
        total++;
        if (o_sv !== 1'b1 || o_sd !== last) begin
            bad++;
            $display("FAIL stop_pending valid=%b data=%0d want 1 %0d", o_sv, o_sd, last);
        end
        total++;
        cycle();
        cycle();
        if (o_sv !== 1'b0 || o_sr !== 1'b0 || ndone !== 0) begin
            bad++;
            $display("FAIL stop_quiet valid=%b src_ready=%b done=%0d want 0 0 0",
                     o_sv, o_sr, ndone);
        end
        total++;
        if (got.size() !== int'(last)) begin
            bad++;
            $display("FAIL inf_count got=%0d want=%0d", got.size(), last);
        end
        total++;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== 24'(i + 1)) begin
                bad++;
                $display("FAIL inf_sample[%0d] got=%0d want=%0d", i, got[i], i + 1);
            end
            total++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        clear_obs();
        ramp = 24'd1;
        snk_if.ready = 1'b1;
        pulse_start(16'd8, 16'd0, 8'd0, 3'd0);
        for (int i = 0; i < 3; i++) cycle();
        if (o_busy !== 1'b1 || o_sv !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre busy=%b valid=%b want 1 1", o_busy, o_sv);
        end
        total++;
        #2;
        reset = 1'b1;
        #1;
        if ({snk_if.valid, busy, src_if.ready} !== 3'b000) begin
            bad++;
            $display("FAIL arst_immediate got=%b want=000",
                     {snk_if.valid, busy, src_if.ready});
        end
        total++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        if (o_busy !== 1'b0 || o_sv !== 1'b0) begin
            bad++;
            $display("FAIL arst_after busy=%b valid=%b want 0 0", o_busy, o_sv);
        end
        total++;
    endtask

    task automatic test_start_filter();
        do_reset();
        clear_obs();
        ramp = 24'd1;
        snk_if.ready = 1'b1;
        pulse_start(16'd0, 16'd1, 8'd1, 3'd0);
        cycle();
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL start_zero_len busy=%b want=0", o_busy);
        end
        total++;
        stop = 1'b1;
        pulse_start(16'd4, 16'd0, 8'd1, 3'd0);
        stop = 1'b0;
        cycle();
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL start_with_stop busy=%b want=0", o_busy);
        end
        total++;
        clear_obs();
        pulse_start(16'd2, 16'd0, 8'd1, 3'd0);
        pulse_start(16'd5, 16'd0, 8'd3, 3'd0);
        for (int i = 0; i < 12; i++) cycle();
        if (got.size() !== 2 || ndone !== 1) begin
            bad++;
            $display("FAIL start_busy_ignored samples=%0d done=%0d want 2 1",
                     got.size(), ndone);
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_bursts();
        test_atten();
        test_back_pressure();
        test_infinite_stop();
        test_async_reset();
        test_start_filter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
